pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter WDT_LIMIT, default 1024, consecutive stalled cycles before watchdog fires.
REQ-002 Parameter EXC_HANDLER, default 32'h0000_0020, exception vector address.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stallreq_if  input  1  fetch stage not ready (instruction memory wait).
REQ-006 stallreq_id  input  1  decode hazard (load-use).
REQ-007 stallreq_ex  input  1  execute busy (multi-cycle div/madd).
REQ-008 stallreq_mem  input  1  memory stage waiting on data bus.
REQ-009 excepttype_i  input  32  exception code from MEM stage; 0 = none; 32'h0000_000e = eret.
REQ-010 cp0_epc_i  input  32  current CP0 EPC value.
REQ-011 stall  output  6  per-stage hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-012 flush  output  1  clear all pipeline registers this cycle.
REQ-013 new_pc  output  32  redirect target, valid only while flush=1.
REQ-014 stall_cycles  output  32  saturating count of cycles with stall!=0.
REQ-015 wdt_timeout  output  1  sticky watchdog flag.

Function
REQ-016 stall and flush SHALL be combinational from inputs and current state (zero-cycle latency); counters and state are registered.
REQ-017 Stall encoding SHALL be: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-018 Simultaneous requests SHALL resolve to the latest-stage encoding (mem > ex > id > if).
REQ-019 FSM states SHALL be RUN, STALL, FLUSH.
REQ-020 RUN -> STALL when any request is active and no exception; STALL -> RUN when all requests drop.
REQ-021 excepttype_i!=0 in RUN or STALL SHALL assert flush=1, force stall=0 that cycle, and transition to FLUSH.
REQ-022 new_pc SHALL be cp0_epc_i when excepttype_i==32'h0000_000e, else EXC_HANDLER; 0 when flush=0.
REQ-023 FLUSH SHALL last exactly one cycle with stall=0 and flush=0; excepttype_i and all requests are ignored; next state RUN.
REQ-024 A watchdog counter SHALL increment each cycle in STALL, clear on any cycle with stall=0, and set wdt_timeout when it reaches WDT_LIMIT.
REQ-025 wdt_timeout SHALL remain set until rst or a flush; the watchdog counter SHALL hold at WDT_LIMIT, not wrap.
REQ-026 stall_cycles SHALL increment when stall!=0, saturate at 32'hFFFF_FFFF, and not clear on flush.
REQ-027 Exception concurrent with watchdog reaching WDT_LIMIT: flush wins; wdt_timeout stays 0.

Reset
REQ-028 rst SHALL override all inputs: state=RUN, stall=0, flush=0, new_pc=0, stall_cycles=0, watchdog counter=0, wdt_timeout=0.
REQ-029 Reset asserted during STALL or FLUSH SHALL take effect on the next edge with no residual flush pulse.

Structure
REQ-030 stall_t (6-bit), ctrl_state_t enum, EXC_ERET and stall encoding constants SHALL live in project_types.
REQ-031 Block SHALL be one module; no sub-module (watchdog is inline).

Verification
REQ-032 stallreq_ex=1 for 3 cycles -> stall=6'b001111 for 3 cycles, stall_cycles=3, then 0.
REQ-033 stallreq_if=1 and stallreq_mem=1 same cycle -> stall=6'b011111.
REQ-034 excepttype_i=32'h0000_0008 during stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h0000_0020; next cycle flush=0, stall=0 despite request.
REQ-035 excepttype_i=32'h0000_000e, cp0_epc_i=32'h8000_0100 -> flush=1, new_pc=32'h8000_0100.
REQ-036 WDT_LIMIT=4, stallreq_id held 6 cycles -> wdt_timeout rises after 4th stalled cycle, stays 1 after release until exception flush.
REQ-037 rst pulsed mid-STALL with stall_cycles=10 -> next cycle stall_cycles=0, stall=0, state RUN.

Source files
------------

// File: rtl/project_types.sv
// project_types -- shared types and constants for the pipeline control block.
//   stall_t       : 6-bit per-stage hold vector
//                   (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB)
//   ctrl_state_t  : RUN / STALL / FLUSH controller states
//   EXC_NONE      : exception code meaning "no exception"
//   EXC_ERET      : exception code for eret (return to CP0 EPC)
//   STALL_*       : hold vector for a request raised by the named stage
//   stall_encode  : priority encoder, the latest stage in the pipe wins
package project_types;

   typedef logic [5:0] stall_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_t;

   localparam logic [31:0] EXC_NONE = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   // A stage that stalls must also hold every stage in front of it.
   localparam stall_t STALL_NONE = 6'b000000;
   localparam stall_t STALL_IF   = 6'b000011;
   localparam stall_t STALL_ID   = 6'b000111;
   localparam stall_t STALL_EX   = 6'b001111;
   localparam stall_t STALL_MEM  = 6'b011111;

   function automatic stall_t stall_encode(input logic req_if, input logic req_id,
                                           input logic req_ex, input logic req_mem);
      stall_t s;
      if (req_mem)     s = STALL_MEM;
      else if (req_ex) s = STALL_EX;
      else if (req_id) s = STALL_ID;
      else if (req_if) s = STALL_IF;
      else             s = STALL_NONE;
      return s;
   endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- pipeline hazard / exception controller with stall watchdog.
//   Parameters : WDT_LIMIT   consecutive stalled cycles before the watchdog fires
//                EXC_HANDLER exception vector address
//   Inputs     : clk, rst (synchronous, active-high)
//                stallreq_if/id/ex/mem  per-stage stall requests
//                excepttype_i           exception code from MEM (0 = none, 0xe = eret)
//                cp0_epc_i              current CP0 EPC
//   Outputs    : stall[5:0]    per-stage hold vector (combinational)
//                flush         clear all pipeline registers (combinational)
//                new_pc        redirect target while flush=1, else 0
//                stall_cycles  saturating count of cycles with stall!=0
//                wdt_timeout   sticky watchdog flag, cleared by rst or flush
//                state_dbg     current controller state (ctrl_state_t encoding)
// Handshake: none; stall/flush are level signals valid in the same cycle as the
// inputs that produce them. The flush cycle is always followed by one quiet
// FLUSH cycle in which every input is ignored.
module pipeline_ctrl
   import project_types::*;
#(
   parameter int          WDT_LIMIT   = 1024,
   parameter logic [31:0] EXC_HANDLER = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        wdt_timeout,
   output logic [1:0]  state_dbg
);

   localparam int               WDT_W   = $clog2(WDT_LIMIT + 1);
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);
   localparam logic [WDT_W-1:0] WDT_ONE = WDT_W'(1);

   ctrl_state_t       state_q, state_d;
   logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
   logic              wdt_timeout_q, wdt_timeout_d;
   logic [31:0]       stall_cycles_q, stall_cycles_d;

   always_comb begin
      state_d = state_q;
      stall   = STALL_NONE;
      flush   = 1'b0;
      new_pc  = 32'h0;
      // Reset masks the combinational outputs too, so no flush or stall
      // escapes during the reset cycle.
      if (!rst) begin
         case (state_q)
            ST_RUN, ST_STALL: begin
               if (excepttype_i != EXC_NONE) begin
                  flush   = 1'b1;
                  new_pc  = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_HANDLER;
                  state_d = ST_FLUSH;
               end else begin
                  stall   = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
                  state_d = (stall != STALL_NONE) ? ST_STALL : ST_RUN;
               end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end

      // Watchdog counts consecutive stalled cycles and parks at the limit.
      if (stall != STALL_NONE)
         wdt_cnt_d = (wdt_cnt_q == WDT_MAX) ? WDT_MAX : wdt_cnt_q + WDT_ONE;
      else
         wdt_cnt_d = '0;

      // A flush always forces stall=0, so an exception coinciding with the
      // limit keeps the flag low.
      if (flush)
         wdt_timeout_d = 1'b0;
      else
         wdt_timeout_d = wdt_timeout_q | (wdt_cnt_d == WDT_MAX);

      if (stall != STALL_NONE && stall_cycles_q != 32'hFFFF_FFFF)
         stall_cycles_d = stall_cycles_q + 32'd1;
      else
         stall_cycles_d = stall_cycles_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_RUN;
         wdt_cnt_q      <= '0;
         wdt_timeout_q  <= 1'b0;
         stall_cycles_q <= 32'h0;
      end else begin
         state_q        <= state_d;
         wdt_cnt_q      <= wdt_cnt_d;
         wdt_timeout_q  <= wdt_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign wdt_timeout  = wdt_timeout_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl -- directed scenarios with literal expectations followed by
// randomized stimulus, all outputs compared every cycle against a behavioural
// model of the controller rules.
module tb_pipeline_ctrl;

   localparam int          LIMIT   = 4;
   localparam logic [31:0] HANDLER = 32'h0000_0020;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_r = 1'b0, id_r = 1'b0, ex_r = 1'b0, mem_r = 1'b0;
   logic [31:0] exc = 32'h0, epc = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        wdt_timeout;
   logic [1:0]  state_dbg;

   pipeline_ctrl #(.WDT_LIMIT(LIMIT), .EXC_HANDLER(HANDLER)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (if_r),
      .stallreq_id  (id_r),
      .stallreq_ex  (ex_r),
      .stallreq_mem (mem_r),
      .excepttype_i (exc),
      .cp0_epc_i    (epc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_cycles (stall_cycles),
      .wdt_timeout  (wdt_timeout),
      .state_dbg    (state_dbg)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
   } exp_t;

   bit          m_ok = 1'b0;       // model has seen a reset edge
   bit          m_after_flush;     // previous cycle flushed -> quiet cycle now
   bit          m_prev_stalled;    // previous cycle had a nonzero hold vector
   int          m_run;             // consecutive stalled cycles, capped at LIMIT
   bit          m_to;
   logic [31:0] m_cyc;

   function automatic exp_t expect_now();
      exp_t e;
      e = '0;
      if (rst || m_after_flush) return e;
      if (exc != 32'h0) begin
         e.flush = 1'b1;
         e.pc    = (exc == 32'h0000_000e) ? epc : HANDLER;
         return e;
      end
      e.stall = mem_r ? 6'd31 : ex_r ? 6'd15 : id_r ? 6'd7 : if_r ? 6'd3 : 6'd0;
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      int   nrun;
      e = expect_now();
      if (rst) begin
         m_ok           <= 1'b1;
         m_after_flush  <= 1'b0;
         m_prev_stalled <= 1'b0;
         m_run          <= 0;
         m_to           <= 1'b0;
         m_cyc          <= 32'h0;
      end else if (m_ok) begin
         nrun = (e.stall != 6'd0) ? ((m_run < LIMIT) ? m_run + 1 : LIMIT) : 0;
         m_run <= nrun;
         if (e.flush) m_to <= 1'b0;
         else if (nrun >= LIMIT) m_to <= 1'b1;
         if (e.stall != 6'd0 && m_cyc != 32'hFFFF_FFFF) m_cyc <= m_cyc + 32'd1;
         m_after_flush  <= e.flush;
         m_prev_stalled <= (e.stall != 6'd0);
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (m_ok) begin
         e = expect_now();
         chk("m_stall",   {26'h0, stall},        {26'h0, e.stall});
         chk("m_flush",   {31'h0, flush},        {31'h0, e.flush});
         chk("m_new_pc",  new_pc,                e.pc);
         chk("m_cycles",  stall_cycles,          m_cyc);
         chk("m_wdt",     {31'h0, wdt_timeout},  {31'h0, m_to});
         chk("m_state",   {30'h0, state_dbg},
             m_after_flush ? 32'd2 : (m_prev_stalled ? 32'd1 : 32'd0));
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic a, input logic b, input logic c,
                        input logic d, input logic [31:0] x, input logic [31:0] p);
      @(posedge clk);
      #1;
      rst = r; if_r = a; id_r = b; ex_r = c; mem_r = d; exc = x; epc = p;
      #3;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst_stall", {26'h0, stall}, 32'h0);
      chk("rst_flush", {31'h0, flush}, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0);
      chk("rst_override_stall", {26'h0, stall}, 32'h0);
      chk("rst_override_flush", {31'h0, flush}, 32'h0);
      chk("rst_new_pc",         new_pc,         32'h0);
      chk("rst_cycles",         stall_cycles,   32'h0);
      chk("rst_wdt",            {31'h0, wdt_timeout}, 32'h0);
      chk("rst_state",          {30'h0, state_dbg},   32'd0);

      // ex stall for three cycles
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
         chk("ex_stall", {26'h0, stall}, 32'h0000_000f);
      end
      idle();
      chk("ex_release_stall", {26'h0, stall}, 32'h0);
      chk("ex_cycles",        stall_cycles,   32'd3);
      chk("ex_no_wdt",        {31'h0, wdt_timeout}, 32'h0);

      // simultaneous if + mem -> mem wins
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk("if_mem_stall", {26'h0, stall}, 32'h0000_001f);
      idle();

      // exception during mem stall
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
      chk("exc_flush",  {31'h0, flush}, 32'h1);
      chk("exc_stall",  {26'h0, stall}, 32'h0);
      chk("exc_new_pc", new_pc,         32'h0000_0020);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
      chk("quiet_flush", {31'h0, flush}, 32'h0);
      chk("quiet_stall", {26'h0, stall}, 32'h0);
      chk("quiet_pc",    new_pc,         32'h0);
      chk("quiet_state", {30'h0, state_dbg}, 32'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk("post_flush_stall", {26'h0, stall}, 32'h0000_001f);
      idle();

      // eret
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h8000_0100);
      chk("eret_flush",  {31'h0, flush}, 32'h1);
      chk("eret_new_pc", new_pc,         32'h8000_0100);
      idle();
      chk("eret_quiet_flush", {31'h0, flush}, 32'h0);
      idle();

      // watchdog: id held six cycles
      for (int k = 1; k <= 6; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         chk("wdt_id_stall", {26'h0, stall}, 32'h0000_0007);
         chk("wdt_rise", {31'h0, wdt_timeout}, (k >= 5) ? 32'h1 : 32'h0);
      end
      idle();
      chk("wdt_sticky1", {31'h0, wdt_timeout}, 32'h1);
      idle();
      chk("wdt_sticky2", {31'h0, wdt_timeout}, 32'h1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
      chk("wdt_flush_cycle", {31'h0, wdt_timeout}, 32'h1);
      idle();
      chk("wdt_cleared", {31'h0, wdt_timeout}, 32'h0);
      idle();

      // reset mid-stall with ten stalled cycles counted
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("mid_cycles10",  stall_cycles, 32'd10);
      chk("mid_state",     {30'h0, state_dbg}, 32'd1);
      chk("mid_rst_stall", {26'h0, stall}, 32'h0);
      idle();
      chk("after_rst_cycles", stall_cycles, 32'h0);
      chk("after_rst_stall",  {26'h0, stall}, 32'h0);
      chk("after_rst_flush",  {31'h0, flush}, 32'h0);
      chk("after_rst_state",  {30'h0, state_dbg}, 32'd0);

      // exception just before the watchdog limit
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
      chk("race_flush", {31'h0, flush}, 32'h1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("race_wdt", {31'h0, wdt_timeout}, 32'h0);
      idle();

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         logic        r;
         logic [31:0] x;
         int          sel;
         r   = ($urandom_range(0, 199) == 0);
         sel = $urandom_range(0, 15);
         x   = (sel == 0) ? ($urandom_range(1, 13) + 32'h0) :
               (sel == 1) ? 32'h0000_000e : 32'h0;
         drive(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), x, $urandom);
      end

      idle();
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
